uart_mem_loader: RTL
====================

// Module: uart_mem_loader
// PURPOSE
//  Parametrised UART program loader: receives a framed byte stream on rx and writes it into
//  external memory (RAM or cartridge flash) while the CPU is held in reset. Successor to the
//  fixed 21-bit raw loader: adds address/length framing, additive checksum, configurable bit
//  timing and write-strobe width, error reporting. Sits beside the CPU and drives the shared
//  address/data/n_write pins through the top-level mux when enable=1.
// PARAMETERS
//  ADR_WIDTH      21   memory address width; ADR_BYTES=(ADR_WIDTH+7)/8 address bytes per 'A'
//  CLKS_PER_BIT   104  clk cycles per UART bit (12 MHz / 115200); must be >= 8
//  WRITE_CYCLES   4    clk cycles write is held high; must be >= 1
// PORTS
//  clk        in   1          system clock
//  n_reset    in   1          asynchronous active-low reset
//  enable     in   1          loader owns the memory bus; 0 -> parser idle
//  rx         in   1          UART RX, 8N1, LSB first, idle high; asynchronous
//  adr        out  ADR_WIDTH  memory address
//  data       out  8          write data
//  write      out  1          active-high write strobe
//  busy       out  1          frame in progress or write sequencer not idle
//  done       out  1          1-cycle pulse: 'W' frame accepted with good checksum
//  frame_err  out  1          sticky: stop bit was 0
//  cksum_err  out  1          sticky: checksum mismatch
// BEHAVIOUR
//  Reset (async, n_reset=0): adr=0, data=0, write=0, busy=0, done=0, both errs=0, all FSMs idle.
//  RX: 2-FF synchroniser; falling edge starts bit timer; resample at CLKS_PER_BIT/2, if high ->
//   glitch, back to idle; data bits sampled every CLKS_PER_BIT at bit centre; stop bit at centre:
//   1 -> byte_valid pulse, 0 -> frame_err=1, byte dropped, parser forced to P_IDLE.
//  Protocol (bytes):  'A'(0x41) a0..a[ADR_BYTES-1] little-endian -> adr; bits >= ADR_WIDTH ignored.
//                     'W'(0x57) len_lo len_hi d0..d[len-1] cks; cks = sum(d) mod 256.
//   Any other byte in P_IDLE ignored. Accepting 'A' or 'W' in P_IDLE clears both sticky errs.
//  Parser states: P_IDLE -> P_ADR (count ADR_BYTES) -> P_IDLE
//                 P_IDLE -> P_LEN0 -> P_LEN1 -> P_DATA (len>0) | P_CSUM (len==0) ;
//                 P_DATA -> P_CSUM after len-th byte ; P_CSUM -> P_IDLE.
//   P_CSUM: match -> done pulse the cycle after byte_valid; mismatch -> cksum_err=1. Data already
//   written is not rolled back. len=0 requires cks=0x00.
//  Write sequencer per data byte: W_IDLE -> W_SETUP (data latched, 1 cycle) -> W_PULSE
//   (write=1, WRITE_CYCLES cycles) -> W_HOLD (1 cycle) -> W_IDLE, adr+=1 on W_HOLD exit.
//   adr/data stable from W_SETUP through W_HOLD. adr wraps modulo 2^ADR_WIDTH (all-ones -> 0).
//   Latency byte_valid -> write rising: 2 cycles. Next byte cannot arrive earlier than 10 bit
//   times; elaboration-time check WRITE_CYCLES+3 < 10*CLKS_PER_BIT, so no overrun is possible.
//  'A' received while sequencer busy: new adr takes effect only after current W_HOLD.
//  enable=0: parser -> P_IDLE at once, RX keeps running but bytes discarded; a write pulse in
//   progress completes (no truncated strobe), then sequencer idles. Errs hold value.
//  busy = (parser != P_IDLE) | (sequencer != W_IDLE).
// STRUCTURE
//  Shared package loader_pkg: parser/sequencer state enums, CMD_ADR=8'h41, CMD_WRITE=8'h57.
//  Sub-module uart_rx (CLKS_PER_BIT) -> byte, byte_valid, stop_err; reusable elsewhere.
//  Parser FSM, 16-bit length counter, 8-bit checksum accumulator, write sequencer in this module.
// TESTING
//  1 'A' 34 12 1F, 'W' 03 00 AA BB CC 31 -> writes AA@0x1F1234, BB@0x1F1235, CC@0x1F1236;
//    write high exactly 4 cycles each; done pulses once; errs 0.
//  2 Same frame with cks 0x30 -> three writes occur, done never pulses, cksum_err=1; next 'A'
//    clears it.
//  3 'A' FF FF FF, 'W' 02 00 11 22 33 -> 0x11@0x1FFFFF, 0x22@0x000000 (wrap).
//  4 Byte with stop bit 0 mid-'W' payload -> frame_err=1, parser P_IDLE, busy falls, no
//    further writes from remaining payload bytes (unless they look like commands).
//  5 n_reset low during W_PULSE -> write drops asynchronously, all outputs at reset values;
//    deassert enable during W_PULSE -> pulse still lasts 4 cycles, later bytes ignored.
//  6 'W' 00 00 00 -> no writes, done pulses; 1/2-bit low glitch on rx -> no byte, no errs.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared command codes and state encodings for the UART
//                memory loader and its receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam logic [7:0] CMD_ADR   = 8'h41;  // 'A' : set write address
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W' : length, payload, checksum

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_ADR  = 3'd1,
    P_LEN0 = 3'd2,
    P_LEN1 = 3'd3,
    P_DATA = 3'd4,
    P_CSUM = 3'd5
  } parser_state_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_SETUP = 2'd1,
    W_PULSE = 2'd2,
    W_HOLD  = 2'd3
  } wseq_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_loader_if
//  Description : Control, serial input and memory-bus signals of the loader.
//                slave = loader side, master = host / bus-mux side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_mem_loader_if #(
  parameter int ADR_WIDTH = 21
);
  logic                 enable;
  logic                 rx;
  logic [ADR_WIDTH-1:0] adr;
  logic [7:0]           data;
  logic                 write;
  logic                 busy;
  logic                 done;
  logic                 frame_err;
  logic                 cksum_err;

  modport slave (
    input  enable, rx,
    output adr, data, write, busy, done, frame_err, cksum_err
  );

  modport master (
    output enable, rx,
    input  adr, data, write, busy, done, frame_err, cksum_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first. Rejects start-bit glitches
//                shorter than half a bit; flags a low stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_stop_err
);

  localparam int                 c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [1:0]         r_sync;
  logic               r_prev;
  rx_state_t          r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic               r_stop_err;
  logic               w_rx;
  logic               w_fall;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;

  // Two-flop synchroniser plus one-cycle history for falling-edge detection
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_prev <= w_rx;
    end
  end

  // Bit-timing FSM: half-bit start check, then sample each bit at its centre
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_cnt == c_half) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == c_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == c_full) begin
            r_cnt        <= '0;
            r_byte_valid <= w_rx;
            r_stop_err   <= ~w_rx;
            r_state      <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_stop_err   = r_stop_err;

endmodule
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_loader
//  Description : Receives 'A'/'W' framed UART stream and writes payload bytes
//                to external memory with a fixed-width write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int ADR_WIDTH    = 21,
  parameter int CLKS_PER_BIT = 104,
  parameter int WRITE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  uart_mem_loader_if.slave   bus
);

  localparam int                 c_adr_bytes = (ADR_WIDTH + 7) / 8;
  localparam logic [3:0]         c_adr_last  = 4'(c_adr_bytes - 1);
  localparam int                 c_wc_w      = $clog2(WRITE_CYCLES + 1);
  localparam logic [c_wc_w-1:0]  c_wc_last   = c_wc_w'(WRITE_CYCLES - 1);

  generate
    if (CLKS_PER_BIT < 8 || WRITE_CYCLES < 1 || WRITE_CYCLES + 3 >= 10 * CLKS_PER_BIT) begin : g_param_check
      $error("uart_mem_loader: illegal CLKS_PER_BIT / WRITE_CYCLES combination");
    end
  endgenerate

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_stop_err;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .n_reset      (n_reset),
    .i_rx         (bus.rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_stop_err   (w_stop_err)
  );

  parser_state_t             r_pstate;
  logic [3:0]                r_adr_cnt;
  logic [c_adr_bytes*8-1:0]  r_adr_buf;
  logic                      r_adr_load;
  logic [15:0]               r_len;
  logic [7:0]                r_cksum;
  logic                      r_done;
  logic                      r_frame_err;
  logic                      r_cksum_err;
  logic [c_adr_bytes*8-1:0]  w_adr_next;
  logic                      w_wr_req;

  wseq_state_t               r_wstate;
  logic [c_wc_w-1:0]         r_wcnt;
  logic [ADR_WIDTH-1:0]      r_adr;
  logic [ADR_WIDTH-1:0]      r_adr_pend_val;
  logic                      r_adr_pend;
  logic [7:0]                r_data;
  logic                      r_write;

  // Address bytes arrive little-endian: shift each new byte in from the top
  generate
    if (c_adr_bytes > 1) begin : g_adr_multi
      assign w_adr_next = {w_byte, r_adr_buf[c_adr_bytes*8-1:8]};
    end else begin : g_adr_single
      assign w_adr_next = w_byte;
    end
  endgenerate

  // Combinational so the strobe rises two cycles after the byte is received
  assign w_wr_req = w_byte_valid & bus.enable & (r_pstate == P_DATA);

  // Frame parser: command decode, address assembly, length and checksum
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pstate    <= P_IDLE;
      r_adr_cnt   <= 4'd0;
      r_adr_buf   <= '0;
      r_adr_load  <= 1'b0;
      r_len       <= 16'd0;
      r_cksum     <= 8'd0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_cksum_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_adr_load <= 1'b0;
      if (!bus.enable) begin
        r_pstate <= P_IDLE;
      end else if (w_stop_err) begin
        r_frame_err <= 1'b1;
        r_pstate    <= P_IDLE;
      end else if (w_byte_valid) begin
        case (r_pstate)
          P_IDLE: begin
            if (w_byte == CMD_ADR) begin
              r_frame_err <= 1'b0;
              r_cksum_err <= 1'b0;
              r_adr_cnt   <= 4'd0;
              r_pstate    <= P_ADR;
            end else if (w_byte == CMD_WRITE) begin
              r_frame_err <= 1'b0;
              r_cksum_err <= 1'b0;
              r_cksum     <= 8'd0;
              r_pstate    <= P_LEN0;
            end
          end
          P_ADR: begin
            r_adr_buf <= w_adr_next;
            if (r_adr_cnt == c_adr_last) begin
              r_adr_load <= 1'b1;
              r_pstate   <= P_IDLE;
            end else begin
              r_adr_cnt <= r_adr_cnt + 4'd1;
            end
          end
          P_LEN0: begin
            r_len[7:0] <= w_byte;
            r_pstate   <= P_LEN1;
          end
          P_LEN1: begin
            r_len[15:8] <= w_byte;
            r_pstate    <= ({w_byte, r_len[7:0]} == 16'd0) ? P_CSUM : P_DATA;
          end
          P_DATA: begin
            r_cksum <= r_cksum + w_byte;
            r_len   <= r_len - 16'd1;
            if (r_len == 16'd1) begin
              r_pstate <= P_CSUM;
            end
          end
          P_CSUM: begin
            if (w_byte == r_cksum) begin
              r_done <= 1'b1;
            end else begin
              r_cksum_err <= 1'b1;
            end
            r_pstate <= P_IDLE;
          end
          default: r_pstate <= P_IDLE;
        endcase
      end
    end
  end

  // Write sequencer: setup, fixed-width strobe, hold, then advance address.
  // A new 'A' address is parked until the sequencer is between writes.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wstate       <= W_IDLE;
      r_wcnt         <= '0;
      r_adr          <= '0;
      r_adr_pend     <= 1'b0;
      r_adr_pend_val <= '0;
      r_data         <= 8'd0;
      r_write        <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_adr_pend) begin
            r_adr      <= r_adr_pend_val;
            r_adr_pend <= 1'b0;
          end
          if (w_wr_req) begin
            r_data   <= w_byte;
            r_wstate <= W_SETUP;
          end
        end
        W_SETUP: begin
          r_write  <= 1'b1;
          r_wcnt   <= '0;
          r_wstate <= W_PULSE;
        end
        W_PULSE: begin
          if (r_wcnt == c_wc_last) begin
            r_write  <= 1'b0;
            r_wstate <= W_HOLD;
          end else begin
            r_wcnt <= r_wcnt + c_wc_w'(1);
          end
        end
        W_HOLD: begin
          if (r_adr_pend) begin
            r_adr      <= r_adr_pend_val;
            r_adr_pend <= 1'b0;
          end else begin
            r_adr <= r_adr + ADR_WIDTH'(1);
          end
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
      // A freshly completed address frame overrides any older parked one
      if (r_adr_load) begin
        r_adr_pend     <= 1'b1;
        r_adr_pend_val <= r_adr_buf[ADR_WIDTH-1:0];
      end
    end
  end

  assign bus.adr       = r_adr;
  assign bus.data      = r_data;
  assign bus.write     = r_write;
  assign bus.done      = r_done;
  assign bus.frame_err = r_frame_err;
  assign bus.cksum_err = r_cksum_err;
  assign bus.busy      = (r_pstate != P_IDLE) || (r_wstate != W_IDLE);

endmodule
`default_nettype wire
